ins_fetch: RTL and testbench
============================

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter PC_W, default 8, program counter and ROM address width.
REQ-002 Parameter RESET_PC, default 8'h00, PC value after reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 CS_Ins_load  input  1  capture the current ROM word into the word-1 or word-2 register.
REQ-006 CS_PC_load  input  1  copy the current PC into the saved-PC register.
REQ-007 CS_PC_inc  input  1  increment the PC by 1.
REQ-008 IF_jmp  input  1  load the PC from IF_jmp_addr.
REQ-009 IF_jmp_addr  input  PC_W  jump target.
REQ-010 IF_rom_data  input  16  instruction ROM read data; asynchronous read of IF_rom_addr.
REQ-011 IF_rom_addr  output  PC_W  equals the PC register (combinational).
REQ-012 IF_opcode  output  4  IR[15:12]; feeds the control-signal FSM opcode input.
REQ-013 IF_rd  output  3  IR[11:9], destination register.
REQ-014 IF_rs  output  3  IR[8:6], source register.
REQ-015 IF_imm  output  16  second-word register (immediate or address for MVI/LDA).
REQ-016 IF_imm_valid  output  1  IF_imm holds the second word of the instruction currently in IR.
REQ-017 IF_two_word  output  1  IR opcode is 4'b1100 (MVI) or 4'b1101 (LDA).
REQ-018 IF_pc_saved  output  PC_W  PC captured by CS_PC_load.
REQ-019 IF_illegal  output  1  one-cycle pulse on a word-1 capture whose opcode is 4'b1110 or 4'b1111.
REQ-020 IF_wrap  output  1  one-cycle pulse when an increment takes the PC from all-ones to 0.

Function
REQ-021 The word FSM SHALL have two states: WORD1 (next capture is an opcode word) and WORD2 (next capture is an immediate word).
REQ-022 In WORD1, on CS_Ins_load: IR <= IF_rom_data; IF_imm_valid <= 0; the FSM SHALL move to WORD2 if IF_rom_data[15:12] is 1100 or 1101, and SHALL otherwise stay in WORD1.
REQ-023 In WORD2, on CS_Ins_load: IF_imm <= IF_rom_data; IF_imm_valid <= 1; IR SHALL hold its value; the FSM SHALL return to WORD1.
REQ-024 Without CS_Ins_load, the FSM state, IR and IF_imm SHALL hold.
REQ-025 PC update priority SHALL be rst > IF_jmp > CS_PC_inc; when both IF_jmp and CS_PC_inc are high, IF_jmp wins and no increment occurs.
REQ-026 PC increment SHALL be modulo 2^PC_W; IF_wrap is registered and SHALL be high the cycle after the wrapping edge.
REQ-027 IF_jmp SHALL force the FSM to WORD1 and clear IF_imm_valid, unless CS_Ins_load is high in the same cycle, in which case the capture SHALL complete first and the FSM is then forced to WORD1.
REQ-028 On a cycle with both CS_Ins_load and CS_PC_inc high, the capture SHALL use the pre-increment PC word (the word at the current IF_rom_addr).
REQ-029 CS_PC_load SHALL capture the pre-update PC, independent of any simultaneous increment or jump.
REQ-030 IF_illegal is registered; IR SHALL still load the illegal word; the FSM SHALL stay in WORD1.
REQ-031 IF_two_word SHALL be decoded combinationally from IR.

Reset
REQ-032 While rst is high at a clock edge: PC = RESET_PC, IR = 16'h0000, IF_imm = 16'h0000, IF_imm_valid = 0, IF_pc_saved = 0, IF_illegal = 0, IF_wrap = 0, FSM = WORD1.
REQ-033 rst SHALL override all other inputs in the same cycle, including mid-instruction in WORD2 (the pending immediate is discarded).

Verification
REQ-034 Reset, then ROM[0]=16'h0A40 with Ins_load+PC_load, then PC_inc -> opcode 0000, rd=5, rs=1, pc_saved=0, PC=1, FSM in WORD1.
REQ-035 ROM[1]=16'hC400, ROM[2]=16'h1234; sequence Ins_load / PC_inc / Ins_load / PC_inc -> two_word=1, imm=16'h1234, imm_valid=1, PC=3, IR still 16'hC400.
REQ-036 PC=8'hFF with PC_inc -> PC=8'h00, IF_wrap high for exactly one cycle.
REQ-037 IF_jmp=1 with jmp_addr=8'h40 and PC_inc=1 in the same cycle -> PC=8'h40; if in WORD2 with no Ins_load, FSM goes to WORD1 and imm_valid=0.
REQ-038 Capture of 16'hF000 -> IF_illegal pulses for one cycle, opcode=4'hF, FSM stays in WORD1.
REQ-039 rst asserted while in WORD2 after capturing 16'hD000 -> all outputs at their reset values next cycle; the following capture is treated as word 1.

Source files
------------

// File: rtl/ins_fetch.sv
// Instruction fetch: PC register, one/two-word instruction capture FSM, decode of IR fields.
// Latency: captures, PC updates and the illegal/wrap pulses appear one clock after the controlling edge.
// Backpressure: none; the control FSM strobes CS_* and IF_jmp, and this block acts on them every cycle.
module ins_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            CS_Ins_load,
  input  logic            CS_PC_load,
  input  logic            CS_PC_inc,
  input  logic            IF_jmp,
  input  logic [PC_W-1:0] IF_jmp_addr,
  input  logic [15:0]     IF_rom_data,
  output logic [PC_W-1:0] IF_rom_addr,
  output logic [3:0]      IF_opcode,
  output logic [2:0]      IF_rd,
  output logic [2:0]      IF_rs,
  output logic [15:0]     IF_imm,
  output logic            IF_imm_valid,
  output logic            IF_two_word,
  output logic [PC_W-1:0] IF_pc_saved,
  output logic            IF_illegal,
  output logic            IF_wrap
);

  typedef enum logic {
    WORD1 = 1'b0,  // next capture is an opcode word
    WORD2 = 1'b1   // next capture is the immediate/address word
  } word_state_e;

  word_state_e     state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_saved_q, pc_saved_d;
  // The low six IR bits feed no decoded field, so only IR[15:6] is kept.
  logic [15:6]     ir_q, ir_d;
  logic [15:0]     imm_q, imm_d;
  logic            imm_vld_q, imm_vld_d;
  logic            illegal_q, illegal_d;
  logic            wrap_q, wrap_d;
  logic            rom_two_word;

  // MVI (1100) and LDA (1101) carry a second word.
  assign rom_two_word = (IF_rom_data[15:13] == 3'b110);

  // PC next-state: jump beats increment; wrap flagged when incrementing from all-ones.
  always_comb begin
    pc_d       = pc_q;
    wrap_d     = 1'b0;
    pc_saved_d = pc_saved_q;
    if (IF_jmp) begin
      pc_d = IF_jmp_addr;
    end else if (CS_PC_inc) begin
      pc_d   = pc_q + PC_W'(1);
      wrap_d = &pc_q;
    end
    // Saved PC always takes the value before this cycle's update.
    if (CS_PC_load) begin
      pc_saved_d = pc_q;
    end
  end

  // Word FSM next-state and capture logic; a jump realigns to WORD1 after any same-cycle capture.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    imm_vld_d = imm_vld_q;
    illegal_d = 1'b0;
    if (CS_Ins_load) begin
      if (state_q == WORD1) begin
        ir_d      = IF_rom_data[15:6];
        imm_vld_d = 1'b0;
        illegal_d = (IF_rom_data[15:13] == 3'b111);
        state_d   = rom_two_word ? WORD2 : WORD1;
      end else begin
        imm_d     = IF_rom_data;
        imm_vld_d = 1'b1;
        state_d   = WORD1;
      end
    end
    if (IF_jmp) begin
      state_d = WORD1;
      if (!CS_Ins_load) begin
        imm_vld_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; reset discards any pending immediate.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WORD1;
      pc_q       <= RESET_PC;
      pc_saved_q <= '0;
      ir_q       <= '0;
      imm_q      <= '0;
      imm_vld_q  <= 1'b0;
      illegal_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_saved_q <= pc_saved_d;
      ir_q       <= ir_d;
      imm_q      <= imm_d;
      imm_vld_q  <= imm_vld_d;
      illegal_q  <= illegal_d;
      wrap_q     <= wrap_d;
    end
  end

  assign IF_rom_addr  = pc_q;
  assign IF_opcode    = ir_q[15:12];
  assign IF_rd        = ir_q[11:9];
  assign IF_rs        = ir_q[8:6];
  assign IF_imm       = imm_q;
  assign IF_imm_valid = imm_vld_q;
  assign IF_two_word  = (ir_q[15:13] == 3'b110);
  assign IF_pc_saved  = pc_saved_q;
  assign IF_illegal   = illegal_q;
  assign IF_wrap      = wrap_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed steps push hand-computed expected outputs; a monitor checks them.
// Latency: each expectation describes the outputs one clock after its stimulus edge.
// Backpressure: none; the monitor pops one expectation per clock while any are queued.
module tb_ins_fetch;

  typedef struct packed {
    logic [7:0]  pc;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] imm;
    logic        iv;
    logic        tw;
    logic [7:0]  ps;
    logic        ill;
    logic        wr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ins_load, pc_load, pc_inc, jmp;
  logic [7:0]  jmp_addr;
  logic [15:0] rom_data;
  logic [7:0]  rom_addr;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs;
  logic [15:0] imm;
  logic        imm_valid, two_word, illegal, wrap;
  logic [7:0]  pc_saved;

  logic [15:0] rom [0:255];

  exp_t  exp_q [$];
  string name_q [$];
  exp_t  e;
  int    checks = 0;
  int    errors = 0;

  ins_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .CS_Ins_load (ins_load),
    .CS_PC_load  (pc_load),
    .CS_PC_inc   (pc_inc),
    .IF_jmp      (jmp),
    .IF_jmp_addr (jmp_addr),
    .IF_rom_data (rom_data),
    .IF_rom_addr (rom_addr),
    .IF_opcode   (opcode),
    .IF_rd       (rd),
    .IF_rs       (rs),
    .IF_imm      (imm),
    .IF_imm_valid(imm_valid),
    .IF_two_word (two_word),
    .IF_pc_saved (pc_saved),
    .IF_illegal  (illegal),
    .IF_wrap     (wrap)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set the visible IR fields of the expectation from a full instruction word.
  function automatic exp_t with_ir(input exp_t x, input logic [15:0] w);
    exp_t r;
    r    = x;
    r.op = w[15:12];
    r.rd = w[11:9];
    r.rs = w[8:6];
    r.tw = (w[15:12] == 4'hC) || (w[15:12] == 4'hD);
    return r;
  endfunction

  // Drive one cycle of stimulus, then queue what the outputs must be after that edge.
  task automatic cyc(input logic r, input logic ld, input logic pl, input logic inc,
                     input logic j, input logic [7:0] ja, input exp_t x, input string nm);
    rst      = r;
    ins_load = ld;
    pc_load  = pl;
    pc_inc   = inc;
    jmp      = j;
    jmp_addr = ja;
    @(posedge clk);
    #1;
    rst = 1'b0; ins_load = 1'b0; pc_load = 1'b0; pc_inc = 1'b0; jmp = 1'b0;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  x, a;
      string nm;
      x  = exp_q.pop_front();
      nm = name_q.pop_front();
      a.pc = rom_addr; a.op = opcode; a.rd = rd; a.rs = rs; a.imm = imm;
      a.iv = imm_valid; a.tw = two_word; a.ps = pc_saved; a.ill = illegal; a.wr = wrap;
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL %s: got pc=%h op=%h rd=%0d rs=%0d imm=%h iv=%b tw=%b ps=%h ill=%b wr=%b, want pc=%h op=%h rd=%0d rs=%0d imm=%h iv=%b tw=%b ps=%h ill=%b wr=%b",
                 nm, a.pc, a.op, a.rd, a.rs, a.imm, a.iv, a.tw, a.ps, a.ill, a.wr,
                 x.pc, x.op, x.rd, x.rs, x.imm, x.iv, x.tw, x.ps, x.ill, x.wr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h0A40;
    rom[8'h01] = 16'hC400;
    rom[8'h02] = 16'h1234;
    rom[8'h03] = 16'hF000;
    rom[8'h04] = 16'hD000;
    rom[8'h40] = 16'h2A55;

    rst = 1'b1; ins_load = 1'b0; pc_load = 1'b0; pc_inc = 1'b0; jmp = 1'b0; jmp_addr = 8'h00;

    e = '0;
    cyc(1, 0, 0, 0, 0, 8'h00, e, "reset");
    cyc(1, 0, 0, 0, 0, 8'h00, e, "reset_hold");
    // Single-word instruction with saved PC.
    e = with_ir(e, 16'h0A40);               e.ps = 8'h00;
    cyc(0, 1, 1, 0, 0, 8'h00, e, "w1_capture");
    e.pc = 8'h01;
    cyc(0, 0, 0, 1, 0, 8'h00, e, "inc_to_1");
    // Two-word MVI.
    e = with_ir(e, 16'hC400);
    cyc(0, 1, 0, 0, 0, 8'h00, e, "mvi_word1");
    e.pc = 8'h02;
    cyc(0, 0, 0, 1, 0, 8'h00, e, "inc_to_2");
    e.imm = 16'h1234; e.iv = 1'b1;
    cyc(0, 1, 0, 0, 0, 8'h00, e, "mvi_word2");
    e.pc = 8'h03;
    cyc(0, 0, 0, 1, 0, 8'h00, e, "inc_to_3");
    // Illegal opcode pulse.
    e = with_ir(e, 16'hF000); e.iv = 1'b0; e.ill = 1'b1;
    cyc(0, 1, 0, 0, 0, 8'h00, e, "illegal_pulse");
    e.ill = 1'b0;
    cyc(0, 0, 0, 0, 0, 8'h00, e, "illegal_clear");
    e.pc = 8'h04;
    cyc(0, 0, 0, 1, 0, 8'h00, e, "inc_to_4");
    // LDA first word, then reset mid-instruction.
    e = with_ir(e, 16'hD000);
    cyc(0, 1, 0, 0, 0, 8'h00, e, "lda_word1");
    e = '0;
    cyc(1, 1, 1, 1, 1, 8'h77, e, "reset_in_word2");
    e = with_ir(e, 16'h0A40);
    cyc(0, 1, 0, 0, 0, 8'h00, e, "post_reset_word1");
    // PC wrap.
    e.pc = 8'hFF;
    cyc(0, 0, 0, 0, 1, 8'hFF, e, "jmp_ff");
    e.pc = 8'h00; e.wr = 1'b1;
    cyc(0, 0, 0, 1, 0, 8'h00, e, "wrap_pulse");
    e.wr = 1'b0;
    cyc(0, 0, 0, 0, 0, 8'h00, e, "wrap_clear");
    // Jump beats increment and clears a valid immediate; saved PC is pre-update.
    e.pc = 8'h01;
    cyc(0, 0, 0, 0, 1, 8'h01, e, "jmp_01");
    e = with_ir(e, 16'hC400);
    cyc(0, 1, 0, 0, 0, 8'h00, e, "mvi_word1_b");
    e.pc = 8'h02;
    cyc(0, 0, 0, 1, 0, 8'h00, e, "inc_to_2_b");
    e.imm = 16'h1234; e.iv = 1'b1;
    cyc(0, 1, 0, 0, 0, 8'h00, e, "mvi_word2_b");
    e.pc = 8'h40; e.iv = 1'b0; e.ps = 8'h02;
    cyc(0, 0, 1, 1, 1, 8'h40, e, "jmp_inc_pcload");
    // Jump from WORD2 without a capture realigns to WORD1.
    e.pc = 8'h01;
    cyc(0, 0, 0, 0, 1, 8'h01, e, "jmp_01_c");
    e = with_ir(e, 16'hC400);
    cyc(0, 1, 0, 0, 0, 8'h00, e, "mvi_word1_c");
    e.pc = 8'h40;
    cyc(0, 0, 0, 1, 1, 8'h40, e, "jmp_from_word2");
    e = with_ir(e, 16'h2A55);
    cyc(0, 1, 0, 0, 0, 8'h00, e, "word1_after_jmp");
    // Jump with a same-cycle WORD2 capture: capture completes, then WORD1.
    e.pc = 8'h01;
    cyc(0, 0, 0, 0, 1, 8'h01, e, "jmp_01_d");
    e = with_ir(e, 16'hC400);
    cyc(0, 1, 0, 0, 0, 8'h00, e, "mvi_word1_d");
    e.pc = 8'h02;
    cyc(0, 0, 0, 1, 0, 8'h00, e, "inc_to_2_d");
    e.pc = 8'h40; e.imm = 16'h1234; e.iv = 1'b1;
    cyc(0, 1, 0, 0, 1, 8'h40, e, "jmp_with_capture");
    e = with_ir(e, 16'h2A55); e.iv = 1'b0;
    cyc(0, 1, 0, 0, 0, 8'h00, e, "word1_after_jmp_cap");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
